// File: rtl/keypad_scanner_if.sv
// Keypad-side and event-side signals of keypad_scanner. master = the scanner, slave = keypad model / downstream consumer.
// key_valid is a one-cycle strobe with no ready: the consumer must take key_code in that cycle; key_code holds until the next accept.
interface keypad_scanner_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       digit_pulse;
  logic       enter_pulse;
  logic       done_pulse;
  logic       key_held;

  modport master (
    input  row_in,
    output col_out, key_code, key_valid, digit_pulse, enter_pulse, done_pulse, key_held
  );

  modport slave (
    output row_in,
    input  col_out, key_code, key_valid, digit_pulse, enter_pulse, done_pulse, key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: walks a low column, samples synchronized rows once per column dwell,
// classifies each full frame and debounces press/release over DEBOUNCE_SCANS frames.
module keypad_scanner #(
  parameter int SCAN_DIV       = 12500,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clock,
  input  logic             reset,
  keypad_scanner_if.master kp,
  output logic [1:0]       dbg_state_o
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_SCANS);
  // Nibble {row,col} holds the key code at that position.
  localparam logic [63:0] KEYMAP = {4'hD, 4'hE, 4'hF, 4'h0,
                                    4'hC, 4'h9, 4'h8, 4'h7,
                                    4'hB, 4'h6, 4'h5, 4'h4,
                                    4'hA, 4'h3, 4'h2, 4'h1};

  typedef enum logic [1:0] {IDLE = 2'd0, CAND = 2'd1, PRESSED = 2'd2} state_e;

  logic [3:0]    row_s1_q, row_s2_q;
  logic [DW-1:0] dwell_q;
  logic [1:0]    col_idx_q;
  logic [1:0]    hits_q;
  logic [3:0]    acc_code_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, rel_cnt_q, rel_cnt_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, accept;

  logic          last_dwell, frame_end;
  logic [2:0]    col_hits, tot;
  logic [3:0]    col_code, frame_code;
  logic          frame_none, frame_single;

  always_comb begin
    last_dwell = (dwell_q == DWELL_LAST);
    frame_end  = last_dwell && (col_idx_q == 2'd3);
    col_hits   = 3'd0;
    col_code   = 4'h0;
    for (int r = 0; r < 4; r++) begin
      if (!row_s2_q[r]) begin
        col_hits = col_hits + 3'd1;
        col_code = KEYMAP[{r[1:0], col_idx_q, 2'b00} +: 4];
      end
    end
    // hits_q saturates at 2, so tot > 1 already means MULTI.
    tot          = {1'b0, hits_q} + col_hits;
    frame_code   = (hits_q == 2'd0) ? col_code : acc_code_q;
    frame_none   = (tot == 3'd0);
    frame_single = (tot == 3'd1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_s1_q   <= 4'hF;
      row_s2_q   <= 4'hF;
      dwell_q    <= '0;
      col_idx_q  <= 2'd0;
      hits_q     <= 2'd0;
      acc_code_q <= 4'h0;
    end else begin
      row_s1_q <= kp.row_in;
      row_s2_q <= row_s1_q;
      if (last_dwell) begin
        dwell_q   <= '0;
        col_idx_q <= col_idx_q + 2'd1;
        if (frame_end) begin
          hits_q     <= 2'd0;
          acc_code_q <= 4'h0;
        end else begin
          hits_q <= (tot > 3'd1) ? 2'd2 : tot[1:0];
          if (hits_q == 2'd0) acc_code_q <= col_code;
        end
      end else begin
        dwell_q <= dwell_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rel_cnt_q   <= '0;
      cand_q      <= 4'h0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= accept;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rel_cnt_d = rel_cnt_q;
    cand_d    = cand_q;
    accept    = 1'b0;
    if (frame_end) begin
      case (state_q)
        IDLE: begin
          if (frame_single) begin
            cand_d = frame_code;
            cnt_d  = CW'(1);
            if (DEBOUNCE_SCANS == 1) begin
              state_d   = PRESSED;
              rel_cnt_d = '0;
              accept    = 1'b1;
            end else begin
              state_d = CAND;
            end
          end
        end
        CAND: begin
          if (frame_single && (frame_code == cand_q)) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
            if (cnt_d == CNT_MAX) begin
              state_d   = PRESSED;
              rel_cnt_d = '0;
              accept    = 1'b1;
            end
          end else if (frame_single) begin
            cand_d = frame_code;
            cnt_d  = CW'(1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        PRESSED: begin
          if (frame_none) begin
            rel_cnt_d = (rel_cnt_q == CNT_MAX) ? rel_cnt_q : rel_cnt_q + CW'(1);
            if (rel_cnt_d == CNT_MAX) begin
              state_d   = IDLE;
              rel_cnt_d = '0;
              cnt_d     = '0;
            end
          end else begin
            rel_cnt_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    key_code_d = accept ? cand_d : key_code_q;
  end

  always_comb begin
    kp.col_out     = ~(4'b0001 << col_idx_q);
    kp.key_code    = key_code_q;
    kp.key_valid   = key_valid_q;
    kp.digit_pulse = key_valid_q && (key_code_q != 4'hD) && (key_code_q != 4'hE);
    kp.enter_pulse = key_valid_q && (key_code_q == 4'hE);
    kp.done_pulse  = key_valid_q && (key_code_q == 4'hD);
    kp.key_held    = (state_q == PRESSED);
    dbg_state_o    = state_q;
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a resistive keypad model drives row_in from col_out, and a
// frame-history reference model predicts accepted keys, held state and decoded pulses.
module tb_keypad_scanner;
  localparam int D     = 2;
  localparam int FRAME = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;
  logic [15:0] pressed = '0;

  keypad_scanner_if kp();

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(D)) dut (
    .clock       (clock),
    .reset       (reset),
    .kp          (kp),
    .dbg_state_o (dbg_state)
  );

  always #5 clock = ~clock;

  // Key (r,c) is bit r*4+c of pressed; a row reads low when a pressed key sits on a driven column.
  always_comb begin
    kp.row_in = 4'hF;
    for (int r = 0; r < 4; r++) kp.row_in[r] = ~|(pressed[r*4 +: 4] & ~kp.col_out);
  end

  int n_cmp = 0;
  int n_fail = 0;
  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];
  int dut_digit = 0, dut_enter = 0, dut_done = 0, late_pulses = 0;
  int exp_digit = 0, exp_enter = 0, exp_done = 0;

  int km[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};
  int hist[$];
  int m_rel_idx = -1;
  int m_acc_idx = 0;
  bit m_held = 1'b0;
  logic [3:0] m_code = 4'h0;

  task automatic model_reset();
    hist.delete();
    m_rel_idx = -1;
    m_held    = 1'b0;
    m_code    = 4'h0;
  endtask

  // Frame result: -1 none, -2 multiple keys, else the key code. Accept when the last D frames since
  // the last release are the same single key; release after D empty frames since the accept.
  task automatic model_frame(input logic [15:0] mask);
    int cnt = 0, code = 0, r, n;
    bit ok;
    for (int i = 0; i < 16; i++) if (mask[i]) begin cnt++; code = km[i]; end
    r = (cnt == 0) ? -1 : ((cnt > 1) ? -2 : code);
    hist.push_back(r);
    n = hist.size() - 1;
    if (!m_held) begin
      ok = (r >= 0) && (n - D + 1 > m_rel_idx);
      for (int i = 1; i < D; i++) if (ok && hist[n-i] != r) ok = 1'b0;
      if (ok) begin
        m_held = 1'b1; m_acc_idx = n; m_code = 4'(r);
        exp_q.push_back(m_code);
        if (r == 14) exp_enter++; else if (r == 13) exp_done++; else exp_digit++;
      end
    end else begin
      ok = (r == -1) && (n - D + 1 > m_acc_idx);
      for (int i = 1; i < D; i++) if (ok && hist[n-i] != -1) ok = 1'b0;
      if (ok) begin m_held = 1'b0; m_rel_idx = n; end
    end
  endtask

  task automatic run_frame(input logic [15:0] mask);
    pressed = mask;
    for (int i = 0; i < FRAME; i++) begin
      @(posedge clock); #1;
      if (kp.key_valid) begin
        got_q.push_back(kp.key_code);
        if (i != FRAME - 1) late_pulses++;
      end
      if (kp.digit_pulse) dut_digit++;
      if (kp.enter_pulse) dut_enter++;
      if (kp.done_pulse)  dut_done++;
    end
  endtask

  task automatic step(input logic [15:0] mask, input int frames);
    for (int f = 0; f < frames; f++) begin
      run_frame(mask);
      model_frame(mask);
    end
  endtask

  function automatic logic [15:0] key_bit(input int r, input int c);
    logic [15:0] m;
    m = '0;
    m[r*4 + c] = 1'b1;
    return m;
  endfunction

  task automatic test_reset();
    logic [3:0] exp_cols[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    reset = 1'b1; pressed = '0;
    repeat (3) @(negedge clock);
    n_cmp++; if (kp.col_out !== 4'b1110) begin n_fail++; $display("FAIL reset_col: got %b expected 1110", kp.col_out); end
    n_cmp++; if (kp.key_code !== 4'h0) begin n_fail++; $display("FAIL reset_code: got %h expected 0", kp.key_code); end
    n_cmp++; if ({kp.key_valid, kp.digit_pulse, kp.enter_pulse, kp.done_pulse, kp.key_held} !== 5'b0) begin
      n_fail++; $display("FAIL reset_pulses: got %b expected 00000",
        {kp.key_valid, kp.digit_pulse, kp.enter_pulse, kp.done_pulse, kp.key_held}); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    reset = 1'b0;
    model_reset();
    for (int k = 1; k <= FRAME; k++) begin
      @(posedge clock); #1;
      if (k % 4 == 0) begin
        n_cmp++;
        if (kp.col_out !== exp_cols[(k/4) % 4]) begin
          n_fail++; $display("FAIL scan_col_%0d: got %b expected %b", k, kp.col_out, exp_cols[(k/4) % 4]);
        end
      end
      if (kp.key_valid) got_q.push_back(kp.key_code);
    end
    model_frame('0);
    n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL scan_no_pulse: got %0d pulses expected 0", got_q.size()); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_key5();
    step(key_bit(1, 1), 6);
    n_cmp++; if (got_q.size() != exp_q.size() || (exp_q.size() > 0 && got_q[0] !== exp_q[0])) begin
      n_fail++; $display("FAIL key5_events: got %0d pulses expected %0d (code exp 5)", got_q.size(), exp_q.size()); end
    n_cmp++; if (kp.key_held !== m_held) begin n_fail++; $display("FAIL key5_held: got %b expected %b", kp.key_held, m_held); end
    n_cmp++; if (dut_digit != exp_digit) begin n_fail++; $display("FAIL key5_digit: got %0d expected %0d", dut_digit, exp_digit); end
    step('0, 1);
    n_cmp++; if (kp.key_held !== 1'b1) begin n_fail++; $display("FAIL key5_held_1empty: got %b expected 1", kp.key_held); end
    step('0, 1);
    n_cmp++; if (kp.key_held !== m_held) begin n_fail++; $display("FAIL key5_released: got %b expected %b", kp.key_held, m_held); end
    n_cmp++; if (kp.key_code !== m_code) begin n_fail++; $display("FAIL key5_code_hold: got %h expected %h", kp.key_code, m_code); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 3; i++) begin
      step(key_bit(2, 0), 1);
      step('0, 1);
    end
    n_cmp++; if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL bounce_none: got %0d pulses expected %0d", got_q.size(), exp_q.size()); end
    step(key_bit(2, 0), 4);
    n_cmp++; if (got_q.size() != exp_q.size() || (exp_q.size() > 0 && got_q[0] !== exp_q[0])) begin
      n_fail++; $display("FAIL bounce_accept: got %0d pulses expected %0d", got_q.size(), exp_q.size()); end
    n_cmp++; if (kp.key_code !== m_code) begin n_fail++; $display("FAIL bounce_code: got %h expected %h", kp.key_code, m_code); end
    step('0, 2);
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_enter_done();
    int d0;
    d0 = dut_digit - exp_digit;
    step(key_bit(3, 2), 3);
    n_cmp++; if (dut_enter != exp_enter) begin n_fail++; $display("FAIL enter_pulse: got %0d expected %0d", dut_enter, exp_enter); end
    n_cmp++; if (kp.key_code !== m_code) begin n_fail++; $display("FAIL enter_code: got %h expected %h", kp.key_code, m_code); end
    step('0, 2);
    step(key_bit(3, 3), 3);
    n_cmp++; if (dut_done != exp_done) begin n_fail++; $display("FAIL done_pulse: got %0d expected %0d", dut_done, exp_done); end
    n_cmp++; if (kp.key_code !== m_code) begin n_fail++; $display("FAIL done_code: got %h expected %h", kp.key_code, m_code); end
    n_cmp++; if (dut_digit - exp_digit != d0) begin
      n_fail++; $display("FAIL enter_done_digit: got %0d extra digit pulses expected 0", dut_digit - exp_digit - d0); end
    n_cmp++; if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL enter_done_events: got %0d pulses expected %0d", got_q.size(), exp_q.size()); end
    step('0, 2);
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_multi();
    step(key_bit(0, 0) | key_bit(0, 1), 4);
    n_cmp++; if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL multi_none: got %0d pulses expected %0d", got_q.size(), exp_q.size()); end
    step(key_bit(0, 1), 1);
    n_cmp++; if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL multi_early: got %0d pulses expected %0d", got_q.size(), exp_q.size()); end
    step(key_bit(0, 1), 1);
    n_cmp++; if (got_q.size() != exp_q.size() || (exp_q.size() > 0 && got_q[0] !== exp_q[0])) begin
      n_fail++; $display("FAIL multi_then_2: got %0d pulses expected %0d", got_q.size(), exp_q.size()); end
    n_cmp++; if (kp.key_code !== m_code) begin n_fail++; $display("FAIL multi_code: got %h expected %h", kp.key_code, m_code); end
    step('0, 2);
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    step(key_bit(2, 2), 1);
    repeat (5) @(posedge clock);
    @(negedge clock); reset = 1'b1; #1;
    n_cmp++; if (kp.col_out !== 4'b1110 || kp.key_code !== 4'h0) begin
      n_fail++; $display("FAIL midreset_outputs: got col %b code %h expected 1110 0", kp.col_out, kp.key_code); end
    n_cmp++; if (kp.key_valid !== 1'b0 || kp.key_held !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL midreset_state: got valid %b held %b state %0d expected 0 0 0", kp.key_valid, kp.key_held, dbg_state); end
    @(negedge clock); @(negedge clock); reset = 1'b0;
    model_reset();
    got_q.delete(); exp_q.delete();
    step(key_bit(2, 2), 1);
    n_cmp++; if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL midreset_early: got %0d pulses expected %0d", got_q.size(), exp_q.size()); end
    step(key_bit(2, 2), 1);
    n_cmp++; if (got_q.size() != exp_q.size() || (exp_q.size() > 0 && got_q[0] !== exp_q[0])) begin
      n_fail++; $display("FAIL midreset_accept: got %0d pulses expected %0d", got_q.size(), exp_q.size()); end
    step('0, 2);
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    logic [15:0] mask;
    int a, b;
    for (int s = 0; s < 40; s++) begin
      case ($urandom_range(0, 3))
        0: mask = '0;
        3: begin
          a = $urandom_range(0, 15); b = (a + $urandom_range(1, 15)) % 16;
          mask = '0; mask[a] = 1'b1; mask[b] = 1'b1;
        end
        default: begin mask = '0; mask[$urandom_range(0, 15)] = 1'b1; end
      endcase
      for (int f = $urandom_range(1, 4); f > 0; f--) begin
        step(mask, 1);
        n_cmp++; if (kp.key_held !== m_held || kp.key_code !== m_code) begin
          n_fail++; $display("FAIL rand_frame_%0d: got held %b code %h expected %b %h", s, kp.key_held, kp.key_code, m_held, m_code); end
      end
    end
    step('0, 2);
    n_cmp++; if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_events: got %0d pulses expected %0d", got_q.size(), exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_code_%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
    end
    n_cmp++; if (dut_digit != exp_digit || dut_enter != exp_enter || dut_done != exp_done) begin
      n_fail++; $display("FAIL rand_decode: got d/e/n %0d/%0d/%0d expected %0d/%0d/%0d",
        dut_digit, dut_enter, dut_done, exp_digit, exp_enter, exp_done); end
    n_cmp++; if (late_pulses != 0) begin n_fail++; $display("FAIL pulse_timing: got %0d misplaced pulses expected 0", late_pulses); end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_key5();
    test_bounce();
    test_enter_done();
    test_multi();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Upstream stage of the regression datapath.
- Drives the 4x4 keypad columns, senses the rows, and debounces.
- Emits one-cycle key events: digit, enter (0xE) and done (0xD). These feed the data_in/enter/input_done logic ahead of linear_regression, replacing level-based decode.
- Runs on the system clock; there is no auto-repeat.

Parameters:
- SCAN_DIV, 12500: clock cycles each column is driven low (dwell). Must be >= 4.
- DEBOUNCE_SCANS, 4: consecutive identical full-scan frames needed to accept a press or a release.

Ports:
- clock  input  1  system clock.
- reset  input  1  reset, asynchronous, active-high.
- row_in  input  4  keypad rows, pulled up, active-low; bit r = row r.
- col_out  output  4  column drive, one-hot-low; bit c = column c.
- key_code  output  4  last accepted key code; held until the next accept.
- key_valid  output  1  one-cycle pulse on an accepted press.
- digit_pulse  output  1  key_valid and key_code not 0xD/0xE.
- enter_pulse  output  1  key_valid and key_code == 0xE.
- done_pulse  output  1  key_valid and key_code == 0xD.
- key_held  output  1  high while the accepted key remains pressed (PRESSED state).

Behaviour:
- Reset values: col_out=4'b1110, col_idx=0, dwell counter=0, key_code=0, key_valid/digit/enter/done_pulse=0, key_held=0, state IDLE, all counters 0.
- Column scan:
  - col_out = ~(4'b1 << col_idx).
  - The dwell counter runs 0..SCAN_DIV-1; on SCAN_DIV-1 it wraps and col_idx advances, 3 wrapping to 0.
  - A frame = 4 dwells = 4*SCAN_DIV cycles. The frame ends on the last cycle of column 3's dwell.
- Row sensing:
  - row_in passes through a 2-flop synchronizer.
  - Sampled on the last dwell cycle of each column; pressed = synced bit == 0.
- Keymap (row r, col c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Frame result: NONE (0 pressed bits), SINGLE(code) (exactly 1 across all 4 columns), MULTI (>1). MULTI is treated as "not a valid key".
- FSM, evaluated only at frame end:
  - IDLE: SINGLE(k) -> CAND, cand=k, cnt=1. Otherwise stay IDLE.
  - CAND:
    - SINGLE(cand) -> cnt+1; when cnt reaches DEBOUNCE_SCANS -> PRESSED, and key_valid is pulsed.
    - SINGLE(other) -> restart CAND with the new key, cnt=1.
    - NONE or MULTI -> IDLE.
    - If DEBOUNCE_SCANS=1, the accept happens on the IDLE->CAND frame itself, going straight to PRESSED.
  - PRESSED: key_held=1.
    - NONE -> rel_cnt+1; at DEBOUNCE_SCANS -> IDLE, key_held=0.
    - Any SINGLE/MULTI -> rel_cnt=0, stay PRESSED. A new key cannot be accepted until a full release.
- Accept timing:
  - key_code is registered to cand.
  - key_valid and the decoded pulse go high the cycle after the accepting frame-end sample, for exactly 1 cycle.
  - The frame in which a press begins counts only if the key's column is sampled after the press.
- Latency:
  - Press accept: DEBOUNCE_SCANS frames (+ up to 1 partial frame + 2 synchronizer cycles).
  - Release: DEBOUNCE_SCANS empty frames.
- Reset asserted mid-operation: all state clears immediately and any in-flight pulse is dropped. A key still held after reset deassert must pass full debounce from IDLE.
- Widths: cnt/rel_cnt = $clog2(DEBOUNCE_SCANS+1) bits, saturating.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE_SCANS=2, so one frame = 16 cycles.
- Reset/scan: release reset -> col_out=1110, 1101 after 4 cycles, 1011 after 8, 0111 after 12, back to 1110 at 16. key_code=0, all pulses 0.
- Key '5' (row1 low while col1 driven) held 6 frames -> exactly one key_valid+digit_pulse with key_code=5, key_held=1. After release and 2 empty frames, key_held=0; key_code stays 5.
- Bounce: '7' pressed 1 frame, released 1 frame, repeated 3x -> no key_valid. Then held 4 frames -> one pulse, code 7.
- Press 'E' (row3/col2) -> one enter_pulse, key_code=E. Release, then press 'D' (row3/col3) -> one done_pulse, key_code=D; digit_pulse never high.
- '1'+'2' held together 4 frames -> no pulse (MULTI). Release '1', keep '2' -> one pulse, code 2, after 2 frames.
- Reset pulse during CAND with '9' held -> outputs return to reset values, no pulse. After deassert, '9' still held -> one pulse after 2 full frames.
